// File: rtl/usb_fs_in_ep.sv
// usb_fs_in_ep: single-buffer IN endpoint between an endpoint controller and
// the full-speed transmit path.
//
// The controller fills one packet. The packet closes either when the
// controller asserts in_ep_data_done or when the buffer is full. An IN token
// then gets one of these answers:
//   - NAK while the packet is still being filled,
//   - DATA0/DATA1 once the packet is closed,
//   - STALL while in_ep_stall is high.
// The payload is streamed to the transmitter byte by byte. A host ACK flips
// the data toggle, frees the buffer and pulses in_ep_acked. A retry keeps the
// buffer and lets the next IN token resend it.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   in_ep_req/grant       controller access handshake (granted while filling)
//   in_ep_data_free       buffer can take another byte this cycle
//   in_ep_data_put/data   byte write strobe and byte
//   in_ep_data_done       close current packet (short or zero-length)
//   in_ep_stall           level: answer IN tokens with STALL
//   in_ep_acked           one-cycle pulse after the host ACKs a data packet
//   in_token_valid        IN token for this endpoint (pulse)
//   setup_token           SETUP token for this endpoint (pulse)
//   tx_pkt_start/tx_pid   start of a response packet and its PID
//   tx_data_avail/get     payload byte handshake with the transmitter
//   tx_data               current payload byte
//   ack_received          ACK handshake from the host (pulse)
//   tx_retry              handshake timeout or corrupt response (pulse)
module usb_fs_in_ep #(
    parameter int MAX_PKT_SIZE = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_ep_req,
    output logic       in_ep_grant,
    output logic       in_ep_data_free,
    input  logic       in_ep_data_put,
    input  logic [7:0] in_ep_data,
    input  logic       in_ep_data_done,
    input  logic       in_ep_stall,
    output logic       in_ep_acked,
    input  logic       in_token_valid,
    input  logic       setup_token,
    output logic       tx_pkt_start,
    output logic [3:0] tx_pid,
    output logic       tx_data_avail,
    input  logic       tx_data_get,
    output logic [7:0] tx_data,
    input  logic       ack_received,
    input  logic       tx_retry
);

    localparam int CW = $clog2(MAX_PKT_SIZE + 1);
    localparam int AW = (MAX_PKT_SIZE > 1) ? $clog2(MAX_PKT_SIZE) : 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PKT_SIZE);

    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [1:0] {
        FILL,
        READY,
        SEND,
        WAIT_ACK
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            toggle_q, toggle_d;
    logic            tx_pkt_start_q, tx_pkt_start_d;
    logic [3:0]      tx_pid_q, tx_pid_d;
    logic            acked_q, acked_d;
    logic [7:0]      mem_q [MAX_PKT_SIZE];
    logic [7:0]      mem_d [MAX_PKT_SIZE];

    logic            wr_en;
    logic [CW-1:0]   count_inc;

    assign in_ep_grant     = in_ep_req && (state_q == FILL);
    assign in_ep_data_free = (state_q == FILL) && (count_q < MAX_CNT);
    assign in_ep_acked     = acked_q;
    assign tx_pkt_start    = tx_pkt_start_q;
    assign tx_pid          = tx_pid_q;
    assign tx_data_avail   = (state_q == SEND) && (rd_ptr_q < count_q);
    assign tx_data         = mem_q[rd_ptr_q[AW-1:0]];

    assign wr_en     = in_ep_data_put && in_ep_grant && in_ep_data_free;
    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        rd_ptr_d       = rd_ptr_q;
        toggle_d       = toggle_q;
        tx_pkt_start_d = 1'b0;
        tx_pid_d       = tx_pid_q;
        acked_d        = 1'b0;
        mem_d          = mem_q;

        case (state_q)
            FILL: begin
                if (wr_en) begin
                    mem_d[count_q[AW-1:0]] = in_ep_data;
                    count_d                = count_inc;
                end
                // A byte written together with done is part of the packet.
                // A full buffer closes the packet without waiting for done.
                if (in_ep_data_done || (wr_en && (count_inc == MAX_CNT)))
                    state_d = READY;
            end
            READY: ;
            SEND: begin
                if (tx_data_get && tx_data_avail)
                    rd_ptr_d = rd_ptr_q + 1'b1;
                // Uses the registered pointer, so a zero-length packet leaves
                // SEND one cycle after tx_pkt_start.
                if (rd_ptr_q == count_q)
                    state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ack_received) begin
                    toggle_d = ~toggle_q;
                    count_d  = '0;
                    rd_ptr_d = '0;
                    acked_d  = 1'b1;
                    state_d  = FILL;
                end else if (tx_retry) begin
                    rd_ptr_d = '0;
                    state_d  = READY;
                end
            end
            default: state_d = FILL;
        endcase

        // Token responses are registered, so they appear one cycle after the
        // token. Stall leaves the state alone and keeps the buffer intact.
        if (in_token_valid) begin
            if (in_ep_stall) begin
                tx_pkt_start_d = 1'b1;
                tx_pid_d       = PID_STALL;
            end else if (state_q == FILL) begin
                tx_pkt_start_d = 1'b1;
                tx_pid_d       = PID_NAK;
            end else if (state_q == READY) begin
                tx_pkt_start_d = 1'b1;
                tx_pid_d       = toggle_q ? PID_DATA1 : PID_DATA0;
                rd_ptr_d       = '0;
                state_d        = SEND;
            end
        end

        // SETUP restarts the endpoint. The next data packet uses DATA1.
        if (setup_token) begin
            toggle_d       = 1'b1;
            count_d        = '0;
            rd_ptr_d       = '0;
            state_d        = FILL;
            tx_pkt_start_d = 1'b0;
            tx_pid_d       = tx_pid_q;
            acked_d        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= FILL;
            count_q        <= '0;
            rd_ptr_q       <= '0;
            toggle_q       <= 1'b0;
            tx_pkt_start_q <= 1'b0;
            tx_pid_q       <= 4'b0000;
            acked_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            rd_ptr_q       <= rd_ptr_d;
            toggle_q       <= toggle_d;
            tx_pkt_start_q <= tx_pkt_start_d;
            tx_pid_q       <= tx_pid_d;
            acked_q        <= acked_d;
        end
    end

    // Payload storage needs no reset. count_q alone decides which bytes are valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_usb_fs_in_ep.sv
module tb_usb_fs_in_ep;

    localparam int MAX = 32;
    localparam logic [3:0] DATA0 = 4'b0011;
    localparam logic [3:0] DATA1 = 4'b1011;
    localparam logic [3:0] NAK   = 4'b1010;
    localparam logic [3:0] STALL = 4'b1110;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_ep_req = 1'b0;
    logic       in_ep_grant;
    logic       in_ep_data_free;
    logic       in_ep_data_put = 1'b0;
    logic [7:0] in_ep_data = 8'h00;
    logic       in_ep_data_done = 1'b0;
    logic       in_ep_stall = 1'b0;
    logic       in_ep_acked;
    logic       in_token_valid = 1'b0;
    logic       setup_token = 1'b0;
    logic       tx_pkt_start;
    logic [3:0] tx_pid;
    logic       tx_data_avail;
    logic       tx_data_get = 1'b0;
    logic [7:0] tx_data;
    logic       ack_received = 1'b0;
    logic       tx_retry = 1'b0;

    usb_fs_in_ep #(.MAX_PKT_SIZE(MAX)) dut (
        .clk(clk), .reset(reset),
        .in_ep_req(in_ep_req), .in_ep_grant(in_ep_grant),
        .in_ep_data_free(in_ep_data_free), .in_ep_data_put(in_ep_data_put),
        .in_ep_data(in_ep_data), .in_ep_data_done(in_ep_data_done),
        .in_ep_stall(in_ep_stall), .in_ep_acked(in_ep_acked),
        .in_token_valid(in_token_valid), .setup_token(setup_token),
        .tx_pkt_start(tx_pkt_start), .tx_pid(tx_pid),
        .tx_data_avail(tx_data_avail), .tx_data_get(tx_data_get),
        .tx_data(tx_data), .ack_received(ack_received), .tx_retry(tx_retry)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state: the toggle the host should see next, the bytes
    // of the whole transfer and the slice expected in the current packet.
    bit         toggle_m = 1'b0;
    logic [7:0] xfer [0:127];
    logic [7:0] exp_pkt [0:MAX-1];

    typedef struct {
        bit         setup;
        int         len;
        bit         retry;
        bit         stall;
        int         exp_npkts;
        int         exp_last;
        logic [3:0] exp_pid;
    } vec_t;
    vec_t tbl [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic do_setup();
        setup_token = 1'b1;
        tick();
        setup_token = 1'b0;
        toggle_m = 1'b1;
    endtask

    task automatic token_expect(input logic [3:0] pid, output logic [3:0] seen);
        in_token_valid = 1'b1;
        tick();
        in_token_valid = 1'b0;
        chk("pkt_start", tx_pkt_start, 1'b1);
        chk("tx_pid", tx_pid, pid);
        seen = tx_pid;
        tick();
        chk("pkt_start_pulse", tx_pkt_start, 1'b0);
        chk("no_acked_on_token", in_ep_acked, 1'b0);
    endtask

    task automatic fill(input int n, input bit done_last);
        if (n == 0) begin
            in_ep_data_done = 1'b1;
            tick();
            in_ep_data_done = 1'b0;
        end
        for (int j = 0; j < n; j++) begin
            in_ep_data_put  = 1'b1;
            in_ep_data      = exp_pkt[j];
            in_ep_data_done = done_last && (j == n - 1);
            tick();
        end
        in_ep_data_put  = 1'b0;
        in_ep_data_done = 1'b0;
        chk("free_after_close", in_ep_data_free, 1'b0);
        chk("grant_after_close", in_ep_grant, 1'b0);
    endtask

    task automatic receive(input int n);
        int i = 0;
        int cyc = 0;
        while (i < n && cyc < 500) begin
            tx_data_get = ($urandom_range(0, 3) != 0);
            if (tx_data_get && tx_data_avail) begin
                chk("tx_data", {24'h0, tx_data}, {24'h0, exp_pkt[i]});
                i++;
            end
            tick();
            cyc++;
        end
        tx_data_get = 1'b0;
        if (i < n) begin
            n_chk++;
            n_fail++;
            $display("FAIL rx_timeout: got %0d bytes, required %0d", i, n);
        end
        for (int k = 0; k < 3; k++) begin
            tx_data_get = 1'b1;
            chk("avail_after_payload", tx_data_avail, 1'b0);
            tick();
        end
        tx_data_get = 1'b0;
    endtask

    task automatic do_ack(input bit with_retry);
        ack_received = 1'b1;
        tx_retry     = with_retry;
        tick();
        ack_received = 1'b0;
        tx_retry     = 1'b0;
        chk("acked_pulse", in_ep_acked, 1'b1);
        tick();
        chk("acked_end", in_ep_acked, 1'b0);
        toggle_m = ~toggle_m;
    endtask

    task automatic run_transfer(input bit setup, input int len, input bit retry, input bit stall,
                                input bit ack_retry, output int npk, output int last,
                                output logic [3:0] pid0);
        int off = 0;
        int plen;
        logic [3:0] exp_pid;
        logic [3:0] seen;
        npk = 0;
        last = 0;
        pid0 = 4'h0;
        if (setup) do_setup();
        for (int i = 0; i < len; i++) xfer[i] = 8'($urandom_range(0, 255));
        if (len == 18) begin
            xfer[0] = 8'h12;
            xfer[1] = 8'h01;
        end
        do begin
            plen = (len - off > MAX) ? MAX : len - off;
            for (int j = 0; j < plen; j++) exp_pkt[j] = xfer[off + j];
            token_expect(NAK, seen);
            fill(plen, (off + plen) == len);
            if (plen == MAX && (off + plen) < len) begin
                // Write attempt into a full, closed buffer must be dropped.
                in_ep_data_put = 1'b1;
                in_ep_data     = 8'hEE;
                tick();
                in_ep_data_put = 1'b0;
            end
            if (stall) begin
                in_ep_stall = 1'b1;
                token_expect(STALL, seen);
                in_ep_stall = 1'b0;
            end
            exp_pid = toggle_m ? DATA1 : DATA0;
            token_expect(exp_pid, seen);
            if (npk == 0) pid0 = seen;
            receive(plen);
            if (retry) begin
                tx_retry = 1'b1;
                tick();
                tx_retry = 1'b0;
                chk("no_acked_on_retry", in_ep_acked, 1'b0);
                token_expect(exp_pid, seen);
                receive(plen);
            end
            do_ack(ack_retry);
            off += plen;
            npk++;
            last = plen;
        end while (off < len);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int npk;
        int last;
        logic [3:0] pid0;
        logic [3:0] seen;

        tbl[0] = '{1'b1, 18, 1'b0, 1'b0, 1, 18, DATA1};
        tbl[1] = '{1'b0,  8, 1'b1, 1'b0, 1,  8, DATA0};
        tbl[2] = '{1'b1, 67, 1'b0, 1'b0, 3,  3, DATA1};
        tbl[3] = '{1'b1,  0, 1'b0, 1'b0, 1,  0, DATA1};
        tbl[4] = '{1'b0,  5, 1'b0, 1'b1, 1,  5, DATA0};
        tbl[5] = '{1'b1, 32, 1'b0, 1'b0, 1, 32, DATA1};
        tbl[6] = '{1'b0, 40, 1'b1, 1'b1, 2,  8, DATA0};

        // Reset state.
        reset = 1'b1;
        in_ep_req = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        toggle_m = 1'b0;
        chk("rst_free", in_ep_data_free, 1'b1);
        chk("rst_grant", in_ep_grant, 1'b1);
        chk("rst_acked", in_ep_acked, 1'b0);
        chk("rst_start", tx_pkt_start, 1'b0);
        chk("rst_pid", tx_pid, 4'h0);
        chk("rst_avail", tx_data_avail, 1'b0);
        token_expect(NAK, seen);
        chk("nak_free", in_ep_data_free, 1'b1);

        // Directed transfers from the table.
        for (int t = 0; t < 7; t++) begin
            run_transfer(tbl[t].setup, tbl[t].len, tbl[t].retry, tbl[t].stall, 1'b0,
                         npk, last, pid0);
            chk($sformatf("tbl%0d_npkts", t), npk, tbl[t].exp_npkts);
            chk($sformatf("tbl%0d_last", t), last, tbl[t].exp_last);
            chk($sformatf("tbl%0d_pid", t), pid0, tbl[t].exp_pid);
        end

        // Reset in the middle of SEND drops the packet and returns to DATA0.
        do_setup();
        for (int j = 0; j < 4; j++) exp_pkt[j] = 8'hA0 + 8'(j);
        fill(4, 1'b1);
        token_expect(DATA1, seen);
        tx_data_get = 1'b1;
        chk("mid_send_byte0", {24'h0, tx_data}, {24'h0, exp_pkt[0]});
        tick();
        tx_data_get = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        toggle_m = 1'b0;
        chk("rst_send_free", in_ep_data_free, 1'b1);
        chk("rst_send_avail", tx_data_avail, 1'b0);
        chk("rst_send_pid", tx_pid, 4'h0);
        chk("rst_send_start", tx_pkt_start, 1'b0);
        exp_pkt[0] = 8'h5A;
        exp_pkt[1] = 8'hC3;
        fill(2, 1'b1);
        token_expect(DATA0, seen);
        receive(2);
        do_ack(1'b0);

        // Random transfers checked against the packetisation model.
        for (int k = 0; k < 8; k++) begin
            bit s;
            int len;
            int m_npk;
            int m_last;
            logic [3:0] m_pid;
            s = (k == 0) || ($urandom_range(0, 1) == 1);
            len = $urandom_range(0, 80);
            m_npk = (len == 0) ? 1 : (len + MAX - 1) / MAX;
            m_last = (len == 0) ? 0 : len - (m_npk - 1) * MAX;
            m_pid = (s || toggle_m) ? DATA1 : DATA0;
            run_transfer(s, len, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                         bit'($urandom_range(0, 1)), npk, last, pid0);
            chk($sformatf("rnd%0d_npkts", k), npk, m_npk);
            chk($sformatf("rnd%0d_last", k), last, m_last);
            chk($sformatf("rnd%0d_pid", k), pid0, m_pid);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
